reg_scoreboard: RTL
===================

# reg_scoreboard

Tracks in-flight general-purpose-register writes between decode/issue and writeback. It consumes the per-instruction `write_reg_t` descriptor produced by the decode stage and keeps a pending-write count for each GPR. It stalls issue on read-after-write hazards and releases each entry when writeback retires the write. It sits directly downstream of the write-descriptor decoder and gates the issue handshake into execute.

## Interface
- `PEND_W`, default 2: width of each per-register pending counter. Maximum in-flight writes per register is 2^PEND_W−1.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `issue_valid`, input, 1: an instruction is presented for issue.
- `issue_write`, input, `write_reg_t`: write descriptor of that instruction. Fields used: `valid`, `src`, `dst`. The `value` field is ignored.
- `issue_rs`, input, `creg_addr_t`: first source register.
- `issue_rt`, input, `creg_addr_t`: second source register.
- `issue_use_rs`, input, 1: the instruction reads `issue_rs`.
- `issue_use_rt`, input, 1: the instruction reads `issue_rt`.
- `issue_ready`, output, 1: combinational. The instruction may issue this cycle.
- `wb_valid`, input, 1: a GPR write retires this cycle.
- `wb_dst`, input, `creg_addr_t`: destination register of the retiring write.
- `flush`, input, 1: pipeline flush. Discards all tracking state.
- `busy_mask`, output, 32: registered. Bit i is 1 when register i's count is non-zero. Bit 0 is always 0.
- `stall_load`, output, 1: combinational. Issue is blocked because a source register has a pending load.
- `err_underflow`, output, 1: sticky. Set when a writeback arrives for a register whose count is already 0.

## Operation
- Per-register state, i = 1..31:
  - `cnt[i]`, PEND_W bits.
  - `ld[i]`, 1 bit. Means the youngest pending write to register i comes from memory.
- Register 0 is never tracked. Issue with `dst`=0 and writeback with `wb_dst`=0 are ignored.
- Derived terms:
  - wb_hit(r) = `wb_valid` & (`wb_dst`==r) & (r≠0) & ~`flush`.
  - busy(r) = `cnt[r]`≠0 & ~(`cnt[r]`==1 & wb_hit(r)). A write retiring in the same cycle is bypassed.
  - haz = (`issue_use_rs` & busy(`issue_rs`)) | (`issue_use_rt` & busy(`issue_rt`)).
  - sat = `issue_write.valid` & `dst`≠0 & `cnt[dst]`==max & ~wb_hit(`dst`).
  - `issue_ready` = ~`flush` & ~haz & ~sat. It does not depend on `issue_valid`.
  - `stall_load` = ~`flush` & (a source counted in haz has `ld`=1).
- Fire = `issue_valid` & `issue_ready`.
  - On fire with `issue_write.valid` and `dst`≠0: `cnt[dst]` increments, and `ld[dst]` becomes (`src`==SRC_MEM).
- Writeback with wb_hit(r) and `cnt[r]`>0: `cnt[r]` decrements.
  - If the count reaches 0, `ld[r]` clears.
  - If `cnt[r]`==0, the count stays 0 and `err_underflow` sets.
- Fire and writeback to the same register in one cycle: the count is unchanged, and `ld` takes the issuing instruction's value.
- Fire and writeback to different registers: both updates apply.
- `flush`=1: all counts and `ld` bits clear on the next edge. Fire cannot occur and writeback is ignored that cycle. `err_underflow` is unaffected.
- Counts never wrap: sat blocks issue at max, and underflow is clamped at 0.

## Timing
- Reset (asynchronous): all `cnt` and `ld` = 0, `busy_mask` = 0, `err_underflow` = 0.
  - Immediately after reset with `flush`=0: `issue_ready`=1 and `stall_load`=0.
  - Reset asserted mid-operation drops all pending state at once.
- `issue_ready` and `stall_load` are combinational in the same cycle from the current counts and the `wb_*`/`flush` inputs.
- `busy_mask` reflects state after the edge, so it lags fire/writeback by 1 cycle.
- Hazard latency: a consumer that reads the destination of an issued producer becomes ready in the same cycle the producer's writeback arrives (0-cycle bypass). It stays blocked until then.
- `err_underflow` rises at the edge after the offending writeback and holds until reset.

## Test plan
- Reset → `busy_mask`=0, `issue_ready`=1, `err_underflow`=0. Fire ADDU with `dst`=5 → `busy_mask`=0x20 next cycle.
- Load-use: fire LW `dst`=8 (SRC_MEM), then present `issue_use_rs`, `rs`=8 → `issue_ready`=0, `stall_load`=1. Pulse `wb_dst`=8 → `issue_ready`=1 in that same cycle; `busy_mask`[8]=0 next cycle.
- Saturation with PEND_W=2: fire 3 writes to `dst`=3 → the 4th write to 3 sees `issue_ready`=0. The 4th with a simultaneous `wb_dst`=3 fires, and the count stays 3.
- `dst`=0 and wb to 0: fire with `dst`=0, `use_rs` with `rs`=0 → `issue_ready` stays 1 and `busy_mask`=0.
- Underflow: `wb_valid` with `wb_dst`=9 while idle → `err_underflow`=1 next cycle and stays set; count for 9 stays 0.
- Flush: registers 2, 4, 7 busy, assert `flush` with a simultaneous wb to 2 → `issue_ready`=0 that cycle, `busy_mask`=0 next cycle, `err_underflow` unchanged.

Source files
------------

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module  : reg_scoreboard
// Brief   : GPR pending-write scoreboard; stalls issue on RAW hazards and
//           releases entries as writeback retires them.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_scoreboard_pkg;
    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_CP0  = 2'd2,
        SRC_HILO = 2'd3
    } write_src_t;

    typedef struct packed {
        logic        valid;
        write_src_t  src;
        creg_addr_t  dst;
        logic [31:0] value;
    } write_reg_t;
endpackage

module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        issue_valid,
    input  write_reg_t  issue_write,
    input  creg_addr_t  issue_rs,
    input  creg_addr_t  issue_rt,
    input  logic        issue_use_rs,
    input  logic        issue_use_rt,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  creg_addr_t  wb_dst,
    input  logic        flush,
    output logic [31:0] busy_mask,
    output logic        stall_load,
    output logic        err_underflow
);

    localparam logic [PEND_W-1:0] c_cnt_max = '1;
    localparam logic [PEND_W-1:0] c_cnt_one = PEND_W'(1);

    logic [31:0][PEND_W-1:0] r_cnt;
    logic [31:0]             r_ld;
    logic [31:0]             r_busy_mask;
    logic                    r_err;

    logic [31:0][PEND_W-1:0] w_cnt_nxt;
    logic [31:0]             w_ld_nxt;
    logic [31:0]             w_wb_hit;
    logic [31:0]             w_busy;
    logic [31:0]             w_inc;
    logic [31:0]             w_uf;
    logic [31:0]             w_mask_nxt;
    logic                    w_haz_rs;
    logic                    w_haz_rt;
    logic                    w_sat;
    logic                    w_ready;
    logic                    w_fire;
    logic                    w_new_ld;
    logic                    w_unused_value;

    assign w_unused_value = ^issue_write.value;

    // A write retiring this cycle is bypassed, so a count of 1 being retired
    // no longer counts as busy.
    always_comb begin
        w_wb_hit = '0;
        w_busy   = '0;
        for (int i = 0; i < 32; i++) begin
            w_wb_hit[i] = wb_valid && (wb_dst == 5'(i)) && (i != 0) && !flush;
            w_busy[i]   = (r_cnt[i] != '0) &&
                          !((r_cnt[i] == c_cnt_one) && w_wb_hit[i]);
        end
    end

    always_comb begin
        w_haz_rs = issue_use_rs && w_busy[issue_rs];
        w_haz_rt = issue_use_rt && w_busy[issue_rt];
        w_sat    = issue_write.valid && (issue_write.dst != 5'd0) &&
                   (r_cnt[issue_write.dst] == c_cnt_max) &&
                   !w_wb_hit[issue_write.dst];
        w_ready  = !flush && !w_haz_rs && !w_haz_rt && !w_sat;
        w_fire   = issue_valid && w_ready;
        w_new_ld = (issue_write.src == SRC_MEM);
    end

    assign issue_ready   = w_ready;
    assign stall_load    = !flush && ((w_haz_rs && r_ld[issue_rs]) ||
                                      (w_haz_rt && r_ld[issue_rt]));
    assign busy_mask     = r_busy_mask;
    assign err_underflow = r_err;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_ld_nxt   = r_ld;
        w_inc      = '0;
        w_uf       = '0;
        w_mask_nxt = '0;
        for (int i = 0; i < 32; i++) begin
            w_inc[i] = w_fire && issue_write.valid &&
                       (issue_write.dst == 5'(i)) && (i != 0);
            if (flush) begin
                w_cnt_nxt[i] = '0;
                w_ld_nxt[i]  = 1'b0;
            end else if (w_inc[i] && w_wb_hit[i]) begin
                // Issue and retire cancel; the youngest write is the new one.
                w_ld_nxt[i] = w_new_ld;
                w_uf[i]     = (r_cnt[i] == '0);
            end else if (w_inc[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + c_cnt_one;
                w_ld_nxt[i]  = w_new_ld;
            end else if (w_wb_hit[i]) begin
                if (r_cnt[i] == '0) begin
                    w_uf[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - c_cnt_one;
                    if (r_cnt[i] == c_cnt_one) begin
                        w_ld_nxt[i] = 1'b0;
                    end
                end
            end
            w_mask_nxt[i] = (w_cnt_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_ld        <= '0;
            r_busy_mask <= '0;
            r_err       <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_ld        <= w_ld_nxt;
            r_busy_mask <= w_mask_nxt;
            r_err       <= r_err | (|w_uf);
        end
    end

endmodule

`default_nettype wire
